// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between instruction fetch and the data path,
// data wins by default while a starvation counter guarantees fetch forward progress.
module mem_arbiter #(
    parameter int ADDR     = 16,
    parameter int WORD     = 32,
    parameter int MAX_WAIT = 4,
    parameter int W_CNT    = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_req_i,
    input  logic [ADDR-1:0] if_addr_i,
    output logic            if_gnt_o,
    output logic            if_rvalid_o,
    output logic [WORD-1:0] if_rdata_o,
    input  logic            dm_req_i,
    input  logic            dm_we_i,
    input  logic [ADDR-1:0] dm_addr_i,
    input  logic [WORD-1:0] dm_wdata_i,
    output logic            dm_gnt_o,
    output logic            dm_rvalid_o,
    output logic [WORD-1:0] dm_rdata_o,
    output logic [ADDR-1:0] mem_a_o,
    output logic            mem_w_o,
    output logic [WORD-1:0] mem_d_o,
    input  logic [WORD-1:0] mem_q_i
);
    typedef enum logic [1:0] {NONE, IF_RD, DM_RD} pend_t;

    pend_t            r_pend;
    logic [W_CNT-1:0] r_wait_cnt;
    logic             w_fetch_prio;
    logic             w_if_gnt;
    logic             w_dm_gnt;

    assign w_fetch_prio = (r_wait_cnt == W_CNT'(MAX_WAIT));
    // grants are gated by rst so nothing reaches the memory while reset is held
    assign w_dm_gnt = rst & dm_req_i & ~(if_req_i & w_fetch_prio);
    assign w_if_gnt = rst & if_req_i & ~w_dm_gnt;

    assign if_gnt_o    = w_if_gnt;
    assign dm_gnt_o    = w_dm_gnt;
    assign mem_a_o     = w_dm_gnt ? dm_addr_i : (w_if_gnt ? if_addr_i : '0);
    assign mem_w_o     = w_dm_gnt & dm_we_i;
    assign mem_d_o     = mem_w_o ? dm_wdata_i : '0;
    assign if_rvalid_o = (r_pend == IF_RD);
    assign dm_rvalid_o = (r_pend == DM_RD);
    assign if_rdata_o  = mem_q_i;
    assign dm_rdata_o  = mem_q_i;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pend     <= NONE;
            r_wait_cnt <= '0;
        end else begin
            r_pend     <= w_if_gnt ? IF_RD : ((w_dm_gnt & ~dm_we_i) ? DM_RD : NONE);
            r_wait_cnt <= (if_req_i & ~w_if_gnt) ? (w_fetch_prio ? r_wait_cnt : r_wait_cnt + 1'b1) : '0;
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks of arbitration, read return routing, starvation and reset.
module tb_mem_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        if_req_i = 1'b0;
    logic [15:0] if_addr_i = '0;
    logic        if_gnt_o;
    logic        if_rvalid_o;
    logic [31:0] if_rdata_o;
    logic        dm_req_i = 1'b0;
    logic        dm_we_i = 1'b0;
    logic [15:0] dm_addr_i = '0;
    logic [31:0] dm_wdata_i = '0;
    logic        dm_gnt_o;
    logic        dm_rvalid_o;
    logic [31:0] dm_rdata_o;
    logic [15:0] mem_a_o;
    logic        mem_w_o;
    logic [31:0] mem_d_o;
    logic [31:0] mem_q_i = '0;
    logic [31:0] mem [0:65535];
    int          n_checks = 0;
    int          n_errors = 0;

    mem_arbiter dut (
        .clk(clk), .rst(rst),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
        .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
        .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_addr_i(dm_addr_i),
        .dm_wdata_i(dm_wdata_i), .dm_gnt_o(dm_gnt_o),
        .dm_rvalid_o(dm_rvalid_o), .dm_rdata_o(dm_rdata_o),
        .mem_a_o(mem_a_o), .mem_w_o(mem_w_o), .mem_d_o(mem_d_o), .mem_q_i(mem_q_i)
    );

    always #5 clk = ~clk;

    // synchronous memory: one-cycle read latency, written data visible to later reads
    always @(posedge clk) begin
        if (mem_w_o) mem[mem_a_o] <= mem_d_o;
        mem_q_i <= mem[mem_a_o];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = '0;
        mem[16'h0010] = 32'hDEADBEEF;
        mem[16'h0040] = 32'h11111111;
        mem[16'h0050] = 32'h22222222;
        rst = 1'b1;
        #1 rst = 1'b0;
        if_req_i = 1'b1; if_addr_i = 16'h0008;
        dm_req_i = 1'b1; dm_we_i = 1'b1; dm_addr_i = 16'h0000; dm_wdata_i = 32'h0000005A;
        tick; tick;
        #2;
        chk("rst_if_gnt", 32'(if_gnt_o), 32'd0);
        chk("rst_dm_gnt", 32'(dm_gnt_o), 32'd0);
        chk("rst_mem_w", 32'(mem_w_o), 32'd0);
        chk("rst_mem_a", 32'(mem_a_o), 32'd0);
        chk("rst_mem_d", mem_d_o, 32'd0);
        chk("rst_rvalid", {30'd0, if_rvalid_o, dm_rvalid_o}, 32'd0);
        tick;
        rst = 1'b1;
        #2;
        chk("rel_dm_gnt", 32'(dm_gnt_o), 32'd1);
        chk("rel_if_gnt", 32'(if_gnt_o), 32'd0);
        chk("rel_mem_w", 32'(mem_w_o), 32'd1);
        tick;
        if_req_i = 1'b0; dm_req_i = 1'b0; dm_we_i = 1'b0;
        chk("wr_no_rvalid", {30'd0, if_rvalid_o, dm_rvalid_o}, 32'd0);
        tick;

        if_req_i = 1'b1; if_addr_i = 16'h0010;
        #2;
        chk("f_if_gnt", 32'(if_gnt_o), 32'd1);
        chk("f_dm_gnt", 32'(dm_gnt_o), 32'd0);
        chk("f_mem_a", 32'(mem_a_o), 32'h0010);
        chk("f_mem_w", 32'(mem_w_o), 32'd0);
        tick;
        if_req_i = 1'b0;
        chk("f_if_rvalid", 32'(if_rvalid_o), 32'd1);
        chk("f_if_rdata", if_rdata_o, 32'hDEADBEEF);
        chk("f_dm_rvalid", 32'(dm_rvalid_o), 32'd0);
        tick;
        chk("f_rvalid_once", 32'(if_rvalid_o), 32'd0);

        dm_req_i = 1'b1; dm_we_i = 1'b1; dm_addr_i = 16'h1234; dm_wdata_i = 32'hCAFEF00D;
        #2;
        chk("w_dm_gnt", 32'(dm_gnt_o), 32'd1);
        chk("w_mem_w", 32'(mem_w_o), 32'd1);
        chk("w_mem_a", 32'(mem_a_o), 32'h1234);
        chk("w_mem_d", mem_d_o, 32'hCAFEF00D);
        tick;
        dm_we_i = 1'b0;
        chk("w_no_rvalid", 32'(dm_rvalid_o), 32'd0);
        #2;
        chk("r_mem_w", 32'(mem_w_o), 32'd0);
        chk("r_mem_d", mem_d_o, 32'd0);
        chk("r_dm_gnt", 32'(dm_gnt_o), 32'd1);
        tick;
        dm_req_i = 1'b0;
        chk("r_dm_rvalid", 32'(dm_rvalid_o), 32'd1);
        chk("r_dm_rdata", dm_rdata_o, 32'hCAFEF00D);
        chk("r_if_rvalid", 32'(if_rvalid_o), 32'd0);
        tick;

        if_req_i = 1'b1; if_addr_i = 16'h0030;
        dm_req_i = 1'b1; dm_we_i = 1'b0; dm_addr_i = 16'h0020;
        for (int i = 0; i < 10; i++) begin
            #2;
            chk($sformatf("st_if_gnt%0d", i), 32'(if_gnt_o), 32'(i % 5 == 4));
            chk($sformatf("st_dm_gnt%0d", i), 32'(dm_gnt_o), 32'(i % 5 != 4));
            tick;
            chk($sformatf("st_if_rv%0d", i), 32'(if_rvalid_o), 32'(i % 5 == 4));
            chk($sformatf("st_dm_rv%0d", i), 32'(dm_rvalid_o), 32'(i % 5 != 4));
        end
        if_req_i = 1'b0; dm_req_i = 1'b0;
        tick;

        if_req_i = 1'b1; if_addr_i = 16'h0040;
        #2;
        chk("il_if_gnt", 32'(if_gnt_o), 32'd1);
        tick;
        if_req_i = 1'b0; dm_req_i = 1'b1; dm_we_i = 1'b0; dm_addr_i = 16'h0050;
        chk("il_if_rvalid", 32'(if_rvalid_o), 32'd1);
        chk("il_if_rdata", if_rdata_o, 32'h11111111);
        chk("il_dm_rvalid0", 32'(dm_rvalid_o), 32'd0);
        #2;
        chk("il_dm_gnt", 32'(dm_gnt_o), 32'd1);
        tick;
        dm_req_i = 1'b0;
        chk("il_dm_rvalid", 32'(dm_rvalid_o), 32'd1);
        chk("il_dm_rdata", dm_rdata_o, 32'h22222222);
        chk("il_if_rvalid0", 32'(if_rvalid_o), 32'd0);
        tick;
        chk("il_idle", {30'd0, if_rvalid_o, dm_rvalid_o}, 32'd0);

        if_req_i = 1'b1; if_addr_i = 16'h0010;
        #2;
        chk("mr_if_gnt", 32'(if_gnt_o), 32'd1);
        #3;
        rst = 1'b0;
        if_req_i = 1'b0;
        #1;
        chk("mr_rvalid_in_rst", 32'(if_rvalid_o), 32'd0);
        tick;
        chk("mr_rvalid_n1", 32'(if_rvalid_o), 32'd0);
        rst = 1'b1;
        tick;
        chk("mr_rvalid_rel", {30'd0, if_rvalid_o, dm_rvalid_o}, 32'd0);
        tick;
        chk("mr_rvalid_rel2", {30'd0, if_rvalid_o, dm_rvalid_o}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Shares the single 32x64k memory port between instruction fetch (read-only) and the data-memory path from execute (read/write). Issues at most one memory access per cycle, returns read data with one-cycle latency, and routes it to the issuing requester. Data accesses normally win; a starvation counter guarantees fetch forward progress. Sits between ifetch/execute and the DP_mem32x64k instance in core.

Parameters:
ADDR, 16, address width (memory depth 2^ADDR words)
WORD, 32, data width
MAX_WAIT, 4, consecutive fetch denials after which fetch gets priority (1..15)
W_CNT, 4, width of starvation counter (must hold MAX_WAIT)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-low reset
if_req_i  in  1  fetch requests a read this cycle
if_addr_i  in  ADDR  fetch address
if_gnt_o  out  1  fetch access issued this cycle (combinational)
if_rvalid_o  out  1  if_rdata_o valid (cycle after grant)
if_rdata_o  out  WORD  fetch read data
dm_req_i  in  1  data path requests an access this cycle
dm_we_i  in  1  1 = write, 0 = read
dm_addr_i  in  ADDR  data address
dm_wdata_i  in  WORD  write data
dm_gnt_o  out  1  data access issued this cycle (combinational)
dm_rvalid_o  out  1  dm_rdata_o valid (cycle after read grant)
dm_rdata_o  out  WORD  data read data
mem_a_o  out  ADDR  memory address
mem_w_o  out  1  memory write enable
mem_d_o  out  WORD  memory write data
mem_q_i  in  WORD  memory read data, valid one cycle after address

Behaviour:
- Reset (rst=0, async): pend <= NONE, wait_cnt <= 0. While rst=0 all gnt/rvalid/mem_w_o forced 0, mem_a_o = 0, mem_d_o = 0.
- Registered state: pend in {NONE, IF_RD, DM_RD} (owner of read issued last cycle); wait_cnt[W_CNT-1:0].
- Arbitration (combinational, same cycle as req):
  - fetch_prio = (wait_cnt == MAX_WAIT).
  - only one req -> that requester granted.
  - both req -> dm granted unless fetch_prio, then if granted.
  - no req -> no grant, mem_w_o = 0, mem_a_o holds 0.
- Memory drive: mem_a_o = granted addr; mem_w_o = dm_gnt_o & dm_we_i; mem_d_o = dm_wdata_i when dm write granted, else 0.
- Requester must hold req/addr/we/wdata stable until gnt is seen; a request without grant is not queued, retried next cycle.
- Read return: pend <= IF_RD on if grant, DM_RD on dm read grant, NONE otherwise (including dm write). Next cycle: if_rvalid_o = (pend==IF_RD), dm_rvalid_o = (pend==DM_RD). Both rdata outputs = mem_q_i (meaningful only with rvalid). Latency grant->rvalid exactly 1 cycle; back-to-back grants give rvalid every cycle.
- Starvation counter: if if_req_i & !if_gnt_o -> wait_cnt <= wait_cnt+1, saturating at MAX_WAIT; if if_gnt_o or !if_req_i -> wait_cnt <= 0.
- Write followed by read of same address: read issued next cycle returns new data (memory behaviour, no bypass here).
- Reset mid-operation: pending rvalid dropped; no rvalid emitted after reset release until a new grant.
- Never both gnt high; never rvalid without a grant one cycle earlier.

Test Plan:
- Reset: hold rst=0 with if_req_i=1, dm_req_i=1 -> all gnt/rvalid/mem_w_o=0; release -> dm_gnt_o=1 first cycle.
- Single fetch: if_req_i=1 addr 0x0010, mem returns 0xDEADBEEF -> if_gnt_o=1 cycle N, mem_a_o=0x0010, if_rvalid_o=1 with if_rdata_o=0xDEADBEEF cycle N+1.
- Data write then read: dm write 0x1234 <= 0xCAFEF00D, next cycle dm read 0x1234 -> mem_w_o=1 only first cycle, no rvalid for write, dm_rvalid_o=1 with 0xCAFEF00D after read.
- Contention/starvation: both req held continuously, MAX_WAIT=4 -> dm granted cycles 0-3, if granted cycle 4, counter cleared, pattern repeats (4 dm : 1 if).
- Interleaved returns: if grant N, dm read N+1 -> if_rvalid_o at N+1 only, dm_rvalid_o at N+2 only, rdata matches respective addresses.
- Reset mid-read: grant fetch at N, assert rst at N+0.5 -> if_rvalid_o stays 0 at N+1 and after release until new grant.
